// File: rtl/nlms_weight_update.sv
// Serial NLMS weight update for the 32-tap adaptive FIR: one tap per clock, w_k += mu*e*x_k/n.
// Optional leakage term enabled by defining NLMS_LEAKAGE_EN.
module nlms_weight_update #(
    parameter int unsigned NTAPS    = 32,
    parameter int unsigned MU_SHIFT = 4
`ifdef NLMS_LEAKAGE_EN
    ,
    parameter int unsigned LEAK_SHIFT = 10
`endif
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [13:0]  e,
    input  logic [31:0]  n,
    input  logic [447:0] reff_bus,
    input  logic         wclr,
    output logic         busy,
    output logic         done,
    output logic [511:0] weight_out
);

    typedef enum logic [1:0] {StIdle, StNorm, StUpdate, StDone} state_e;

    state_e      state_q, state_d;
    logic [13:0] e_q, e_d;
    logic [31:0] n_q, n_d;
    logic [5:0]  sh_q, sh_d;
    logic [4:0]  k_q, k_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [15:0] weight_q [NTAPS];
    logic [15:0] weight_d [NTAPS];

    logic [13:0]        x_arr [NTAPS];
    logic [13:0]        x_cur;
    logic [15:0]        w_cur;
    logic [4:0]         lead;
    logic signed [27:0] prod;
    logic signed [42:0] delta;
    logic signed [43:0] sum;
    logic [15:0]        w_new;
`ifdef NLMS_LEAKAGE_EN
    logic signed [15:0] leak;
`endif

    for (genvar i = 0; i < NTAPS; i++) begin : g_unpack
        assign x_arr[i]                = reff_bus[14*i +: 14];
        assign weight_out[16*i +: 16] = weight_q[i];
    end

    assign x_cur = x_arr[k_q];
    assign w_cur = weight_q[k_q];
    assign busy  = busy_q;
    assign done  = done_q;

    // Leading-one position of the energy stands in for 1/n.
    always_comb begin
        lead = '0;
        for (int i = 0; i < 32; i++) begin
            if (n_q[i]) lead = 5'(i);
        end
    end

    always_comb begin
        prod  = $signed(e_q) * $signed(x_cur);
        delta = $signed({prod, 15'd0}) >>> sh_q;
        sum   = {{28{w_cur[15]}}, w_cur} + {delta[42], delta};
`ifdef NLMS_LEAKAGE_EN
        leak  = $signed(w_cur) >>> LEAK_SHIFT;
        sum   = sum - {{28{leak[15]}}, leak};
`endif
        if (sum > 44'sd32767) begin
            w_new = 16'h7fff;
        end else if (sum < -44'sd32768) begin
            w_new = 16'h8000;
        end else begin
            w_new = sum[15:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        e_d      = e_q;
        n_d      = n_q;
        sh_d     = sh_q;
        k_d      = k_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        weight_d = weight_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    e_d     = e;
                    n_d     = n;
                    busy_d  = 1'b1;
                    state_d = StNorm;
                end else if (wclr) begin
                    for (int i = 0; i < NTAPS; i++) weight_d[i] = '0;
                end
            end
            StNorm: begin
                sh_d    = 6'(MU_SHIFT) + {1'b0, lead};
                k_d     = '0;
                state_d = StUpdate;
            end
            StUpdate: begin
                weight_d[k_q] = w_new;
                k_d           = k_q + 5'd1;
                if (k_q == 5'(NTAPS - 1)) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            e_q     <= '0;
            n_q     <= '0;
            sh_q    <= '0;
            k_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < NTAPS; i++) weight_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            e_q      <= e_d;
            n_q      <= n_d;
            sh_q     <= sh_d;
            k_q      <= k_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            weight_q <= weight_d;
        end
    end

endmodule
